// File: rtl/translate_ascii_to_hex.sv
// Streaming ASCII-hex to binary word parser: NUM_BYTES*2 hex digits, MSB first,
// are packed into one word that is presented on a valid/ready output.
module translate_ascii_to_hex #(
    parameter int NUM_BYTES = 2,
    localparam int W  = NUM_BYTES * 8,
    localparam int ND = NUM_BYTES * 2,
    localparam int CW = $clog2(ND + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          err,
    output logic [7:0]    err_char,
    output logic [CW-1:0] digit_count,
    output logic [1:0]    dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready depends only on the state register; out_data is held stable
    // for as long as out_valid is high and out_ready is low.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [W-1:0]  shreg, shreg_n;
    logic [W-1:0]  data_n;
    logic [W-1:0]  shifted;
    logic [CW-1:0] count_n;
    logic          valid_n;
    logic          err_n;
    logic [7:0]    err_char_n;
    logic          is_num, is_upper, is_lower, is_hex, is_sep, accept;
    logic [3:0]    nibble;

    assign in_ready  = (state != HOLD);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            err         <= 1'b0;
            err_char    <= 8'h00;
            digit_count <= '0;
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            out_data    <= data_n;
            out_valid   <= valid_n;
            err         <= err_n;
            err_char    <= err_char_n;
            digit_count <= count_n;
        end
    end

    always_comb begin
        is_num   = (in_data >= 8'h30) && (in_data <= 8'h39);
        is_upper = (in_data >= 8'h41) && (in_data <= 8'h46);
        is_lower = (in_data >= 8'h61) && (in_data <= 8'h66);
        is_hex   = is_num || is_upper || is_lower;
        is_sep   = (in_data == 8'h20) || (in_data == 8'h0D) || (in_data == 8'h0A);
        // Letters 'A'/'a' have low nibble 1, so +9 maps them onto 10..15.
        nibble   = is_num ? in_data[3:0] : (in_data[3:0] + 4'd9);
        accept   = in_valid && in_ready;
        shifted  = {shreg[W-5:0], nibble};
    end

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        data_n     = out_data;
        valid_n    = out_valid;
        count_n    = digit_count;
        err_n      = 1'b0;
        err_char_n = err_char;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_hex) begin
                        shreg_n = {{(W-4){1'b0}}, nibble};
                        count_n = CW'(1);
                        state_n = COLLECT;
                    end else if (!is_sep) begin
                        err_n      = 1'b1;
                        err_char_n = in_data;
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (is_hex) begin
                        if (digit_count == CW'(ND - 1)) begin
                            data_n  = shifted;
                            valid_n = 1'b1;
                            shreg_n = '0;
                            count_n = '0;
                            state_n = HOLD;
                        end else begin
                            shreg_n = shifted;
                            count_n = digit_count + CW'(1);
                        end
                    end else begin
                        // Any non-digit mid-word, separators included, aborts it.
                        err_n      = 1'b1;
                        err_char_n = in_data;
                        shreg_n    = '0;
                        count_n    = '0;
                        state_n    = IDLE;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
                count_n = '0;
                shreg_n = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_translate_ascii_to_hex.sv
// Bench for translate_ascii_to_hex: vector table, hand sequences for stall and
// reset corners, and random traffic checked against a string-level model.
module tb_translate_ascii_to_hex;

    localparam int NUM_BYTES = 2;
    localparam int W  = NUM_BYTES * 8;
    localparam int ND = NUM_BYTES * 2;
    localparam int CW = $clog2(ND + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          err;
    logic [7:0]    err_char;
    logic [CW-1:0] digit_count;
    logic [1:0]    dbg_state;

    translate_ascii_to_hex #(.NUM_BYTES(NUM_BYTES)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .err(err), .err_char(err_char),
        .digit_count(digit_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: pending digits as a queue of nibble values.
    int           digits[$];
    bit           m_hold;
    logic [W-1:0] m_word;
    bit           m_err;
    logic [7:0]   m_err_char;
    logic [W-1:0] exp_q[$];
    int           n_words, n_errs;
    logic [W-1:0] first_word, last_word;
    int           tests = 0, fails = 0;

    typedef struct {
        string        stim;
        int           words;
        logic [W-1:0] first;
        int           errs;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int hex_val(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - int'(8'h30);
        if (c >= "A" && c <= "F") return int'(c) - int'(8'h41) + 10;
        if (c >= "a" && c <= "f") return int'(c) - int'(8'h61) + 10;
        return -1;
    endfunction

    task automatic model_char(input logic [7:0] c);
        int v;
        logic [W-1:0] word;
        v = hex_val(c);
        if (v >= 0) begin
            digits.push_back(v);
            if (digits.size() == ND) begin
                word = '0;
                foreach (digits[i]) word = (word << 4) | W'(digits[i]);
                digits.delete();
                m_word = word;
                m_hold = 1'b1;
                exp_q.push_back(word);
                if (n_words == 0) first_word = word;
                last_word = word;
                n_words++;
            end
        end else if (!((c == 8'h20 || c == 8'h0D || c == 8'h0A) && digits.size() == 0)) begin
            m_err      = 1'b1;
            m_err_char = c;
            digits.delete();
            n_errs++;
        end
    endtask

    // One clock cycle: drive, check pre-edge outputs, clock, update model, check err.
    task automatic step(input bit v, input logic [7:0] c, input bit ordy, output bit accepted);
        bit handshake;
        in_valid = v; in_data = c; out_ready = ordy; rst = 1'b0;
        #1;
        check("in_ready", 64'(in_ready), 64'(!m_hold));
        check("out_valid", 64'(out_valid), 64'(m_hold));
        if (m_hold) check("out_data_hold", 64'(out_data), 64'(m_word));
        check("digit_count", 64'(digit_count), 64'(digits.size()));
        handshake = m_hold && ordy;
        if (handshake) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL word_unexpected: got %0h expected none", out_data);
            end else check("word", 64'(out_data), 64'(exp_q.pop_front()));
        end
        @(posedge clk); #1;
        accepted = 1'b0;
        m_err = 1'b0;
        if (handshake) m_hold = 1'b0;
        else if (v && !m_hold) begin
            accepted = 1'b1;
            model_char(c);
        end
        check("err", 64'(err), 64'(m_err));
        check("err_char", 64'(err_char), 64'(m_err_char));
    endtask

    task automatic send(input string s, input bit ordy);
        bit acc;
        int guard;
        for (int i = 0; i < s.len(); i++) begin
            guard = 0;
            acc = 1'b0;
            while (!acc && guard < 50) begin
                step(1'b1, s[i], ordy, acc);
                guard++;
            end
            if (!acc) begin
                tests++; fails++;
                $display("FAIL accept_timeout: char %0h never accepted, expected acceptance", s[i]);
            end
        end
    endtask

    task automatic drain(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, acc);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        digits.delete(); exp_q.delete();
        m_hold = 1'b0; m_err = 1'b0; m_err_char = 8'h00; m_word = '0;
        n_words = 0; n_errs = 0;
        check("rst_out_data", 64'(out_data), 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        check("rst_err_char", 64'(err_char), 64'h0);
        check("rst_digit_count", 64'(digit_count), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h1);
    endtask

    initial begin
        bit acc;
        string hx;
        int r;
        logic [7:0] c;
        hx = "0123456789abcdefABCDEF";

        vecs[0] = '{"1234", 1, 16'h1234, 0};
        vecs[1] = '{"abCDF0e1", 2, 16'hABCD, 0};
        vecs[2] = '{"ABG5678", 1, 16'h5678, 1};
        vecs[3] = '{" \r\n9F3C\n", 1, 16'h9F3C, 0};
        vecs[4] = '{"12 34", 0, 16'h0000, 1};

        @(posedge clk); #1;
        do_reset();

        for (int i = 0; i < 5; i++) begin
            do_reset();
            send(vecs[i].stim, 1'b1);
            drain(3);
            check($sformatf("vec%0d_words", i), 64'(n_words), 64'(vecs[i].words));
            check($sformatf("vec%0d_errs", i), 64'(n_errs), 64'(vecs[i].errs));
            if (vecs[i].words > 0)
                check($sformatf("vec%0d_first", i), 64'(first_word), 64'(vecs[i].first));
            if (i == 2) check("g_err_char", 64'(err_char), 64'h47);
            if (i == 4) check("sep_err_char", 64'(err_char), 64'h20);
        end

        // Output stall with the next word's first character pending.
        do_reset();
        send("DEAD", 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, "B", 1'b0, acc);
            check("stall_no_accept", 64'(acc), 64'h0);
            check("stall_data", 64'(out_data), 64'hDEAD);
        end
        send("BEEF", 1'b1);
        drain(3);
        check("stall_words", 64'(n_words), 64'h2);
        check("stall_last", 64'(last_word), 64'hBEEF);

        // Reset mid-word and with a word pending.
        do_reset();
        send("12", 1'b1);
        check("mid_digit_count", 64'(digit_count), 64'h2);
        do_reset();
        send("DEAD", 1'b0);
        check("pend_valid", 64'(out_valid), 64'h1);
        do_reset();
        send("0001", 1'b1);
        drain(3);
        check("post_rst_word", 64'(last_word), 64'h0001);
        check("post_rst_words", 64'(n_words), 64'h1);

        // Random traffic with random valid and back-pressure.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 7) c = hx[$urandom_range(0, 21)];
            else if (r == 8) begin
                case ($urandom_range(0, 2))
                    0: c = 8'h20;
                    1: c = 8'h0D;
                    default: c = 8'h0A;
                endcase
            end else c = 8'($urandom_range(0, 255));
            step($urandom_range(0, 3) != 0, c, $urandom_range(0, 2) != 0, acc);
        end
        drain(4);
        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
